// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the async-FIFO read-side streamer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned SKID_DEPTH = 2;

    function automatic int unsigned frame_cnt_width(input int unsigned frame_len);
        return $clog2(frame_len);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: entry 0 is always the head, entry 1 holds the overflow word.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_head
);

    localparam logic [1:0] CNT_FULL = 2'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem0;
    logic [DATA_WIDTH-1:0] r_mem1;
    logic [1:0]            r_count;
    logic                  w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);
    assign o_head  = r_mem0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= '0;
        end else begin
            unique case ({i_push, w_pop})
                2'b10: begin
                    if (r_count != CNT_FULL) begin
                        if (r_count == 2'd0) r_mem0 <= i_push_data;
                        else                 r_mem1 <= i_push_data;
                        r_count <= r_count + 2'd1;
                    end
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                // push+pop: the incoming word lands behind whatever remains after the pop
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_push_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side engine: pulls words from the async FIFO read port and presents them
// as a framed valid/ready stream, hiding the FIFO's registered read latency.
module fifo_rd_streamer
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int unsigned    FCW       = frame_cnt_width(FRAME_LEN);
    localparam logic [FCW-1:0] FRAME_MAX = FCW'(FRAME_LEN - 1);
    localparam logic [2:0]     OCC_LIMIT = 3'(SKID_DEPTH);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_busy;
    logic                  r_inflight;
    logic [FCW-1:0]        r_frame_cnt;
    logic [CNT_WIDTH-1:0]  r_word_count;

    logic [1:0]            w_count;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_r_en;

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk       (rclk),
        .i_rst       (rrst),
        .i_push      (r_inflight),
        .i_push_data (fifo_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_head      (w_head)
    );

    assign w_pop = w_valid && out_ready;

    // Occupancy after this edge if no read were issued; reading only while it is
    // below the buffer depth guarantees the in-flight word always has a slot.
    assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_r_en = (r_state == RUN) && !fifo_empty && (w_occ < OCC_LIMIT);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (en) w_next_state = RUN;
            end
            RUN: begin
                if (!en) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (en)
                    w_next_state = RUN;
                else if (!r_inflight && (w_count == 2'd0) && !w_pop)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_busy     <= (w_next_state != IDLE);
            r_inflight <= w_r_en;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_frame_cnt  <= '0;
            r_word_count <= '0;
        end else if (w_pop) begin
            r_frame_cnt  <= (r_frame_cnt == FRAME_MAX) ? '0 : r_frame_cnt + 1'b1;
            r_word_count <= r_word_count + 1'b1;
        end
    end

    assign fifo_r_en  = w_r_en;
    assign out_valid  = w_valid;
    assign out_data   = w_head;
    assign out_last   = w_valid && (r_frame_cnt == FRAME_MAX);
    assign busy       = r_busy;
    assign word_count = r_word_count;

endmodule
